// File: rtl/bus_arbiter4.sv
// bus_arbiter4: four-requester round-robin arbiter driving a shared data mux.
// Optional grant timeout is compiled in by defining ARBITER_TIMEOUT_EN.

// Four-channel data multiplexer shared across the codebase.
module mux4 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  // Route the selected channel to the output.
  always_comb begin
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end

endmodule

module bus_arbiter4 #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic             done,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [1:0] sel_n;
  logic [3:0] gnt_n;
  logic [1:0] start;
  logic [1:0] win;
  logic       found;
  logic       release_ev;
  logic       expire;

`ifdef ARBITER_TIMEOUT_EN
  logic [15:0] cnt;

  assign expire = (state == GRANT) && (cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;

  assign expire             = 1'b0;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // Release detection, round-robin search and next-state selection.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    gnt_n      = gnt;
    sel_n      = sel;
    release_ev = (state == GRANT) && (done || !req[sel] || expire);
    // A release re-arbitrates in the same cycle, so the search must start
    // from the already-advanced pointer rather than the registered one.
    start      = release_ev ? sel + 2'd1 : ptr;
    found      = 1'b0;
    win        = start;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!found && req[start + 2'(k)]) begin
        found = 1'b1;
        win   = start + 2'(k);
      end
    end
    if (release_ev) begin
      ptr_n = sel + 2'd1;
    end
    if (state == IDLE || release_ev) begin
      if (found) begin
        state_n = GRANT;
        gnt_n   = 4'b0001 << win;
        sel_n   = win;
        if (state == IDLE) begin
          ptr_n = win;
        end
      end else begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    end
  end

  // State, pointer and registered grant outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      sel   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
    end
  end

`ifdef ARBITER_TIMEOUT_EN
  // Grant-length counter and one-cycle forced-release pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= expire && !done && req[sel];
      if (state_n == GRANT && (state == IDLE || release_ev)) begin
        cnt <= '0;
      end else if (state == GRANT) begin
        cnt <= cnt + 16'd1;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign out_valid = (state == GRANT);

  mux4 #(.WIDTH(WIDTH)) u_mux (
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .sel (sel),
    .out (out)
  );

endmodule

// File: tb/tb_bus_arbiter4.sv
// Scoreboard bench for bus_arbiter4: stimulus pushes reference-model
// expectations, a monitor pops and compares them after each clock edge
// and immediately after an asynchronous reset assertion.
module tb_bus_arbiter4;

  localparam int W  = 16;
  localparam int TO = 8;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b1;
  logic [3:0]   req     = '0;
  logic         done    = 1'b0;
  logic [W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [W-1:0] out;
  logic         out_valid;
  logic         timeout;

  always #5 clock = ~clock;

  bus_arbiter4 #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .done      (done),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .gnt       (gnt),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .timeout   (timeout)
  );

  typedef struct {
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         chk_sel;
    logic         valid;
    logic         tmo;
    logic [W-1:0] out;
  } exp_t;

  exp_t  sbq[$];
  string tagq[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_on = 1'b0;

  // Reference model: who holds the resource, where the next search starts,
  // and how many cycles the current holder has had it.
  int           holder = -1;
  int           mptr   = 0;
  int           age    = 0;
  logic [W-1:0] din[4];

  function automatic void chk(input string tag, input string what,
                              input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, what, got, want);
    end
  endfunction

  task automatic push_exp(input bit tmo, input string tag);
    exp_t e;
    e.valid   = (holder >= 0);
    e.gnt     = (holder >= 0) ? 4'(1 << holder) : 4'b0000;
    e.sel     = (holder >= 0) ? holder[1:0] : 2'd0;
    e.chk_sel = (holder >= 0);
    e.tmo     = tmo;
    e.out     = (holder >= 0) ? din[holder[1:0]] : '0;
    sbq.push_back(e);
    tagq.push_back(tag);
  endtask

  task automatic push_reset(input string tag);
    exp_t e;
    e.valid = 1'b0; e.gnt = '0; e.sel = '0; e.chk_sel = 1'b1;
    e.tmo   = 1'b0; e.out = '0;
    sbq.push_back(e);
    tagq.push_back(tag);
  endtask

  task automatic model_step(input logic [3:0] r, input logic d, input string tag);
    bit rel = 1'b0;
    bit tmo = 1'b0;
    if (holder >= 0) begin
      if (d || !r[holder[1:0]]) rel = 1'b1;
`ifdef ARBITER_TIMEOUT_EN
      else if (age == TO - 1) begin
        rel = 1'b1;
        tmo = 1'b1;
      end
`endif
      if (rel) mptr = (holder + 1) % 4;
      else     age++;
    end
    if (holder < 0 || rel) begin
      holder = -1;
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (mptr + k) % 4;
        if (holder < 0 && r[idx[1:0]]) begin
          holder = idx;
          age    = 0;
        end
      end
    end
    push_exp(tmo, tag);
  endtask

  task automatic cycle(input logic [3:0] r, input logic d, input string tag);
    @(negedge clock);
    req = r;
    done = d;
    in0 = W'($urandom); in1 = W'($urandom); in2 = W'($urandom); in3 = W'($urandom);
    din[0] = in0; din[1] = in1; din[2] = in2; din[3] = in3;
    model_step(r, d, tag);
  endtask

  // Asserts reset away from any clock edge, holds it across one rising
  // edge and releases it on a falling edge.
  task automatic do_reset(input string tag);
    @(negedge clock);
    #2;
    req  = '0;
    done = 1'b0;
    push_reset({tag, "_async"});
    mon_on  = 1'b1;
    reset_n = 1'b0;
    holder = -1; mptr = 0; age = 0;
    push_reset({tag, "_hold"});
    @(negedge clock);
    reset_n = 1'b1;
    model_step(4'b0000, 1'b0, {tag, "_rel"});
  endtask

  // Monitor: compare DUT outputs with the oldest expectation.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge clock or negedge reset_n);
      #1;
      if (mon_on) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
          e = sbq.pop_front();
          t = tagq.pop_front();
          chk(t, "gnt", W'(gnt), W'(e.gnt));
          chk(t, "out_valid", W'(out_valid), W'(e.valid));
          chk(t, "timeout", W'(timeout), W'(e.tmo));
          chk(t, "onehot", W'($onehot0(gnt)), W'(1));
          if (e.chk_sel) chk(t, "sel", W'(sel), W'(e.sel));
          if (e.valid)   chk(t, "out", out, e.out);
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic       d;

    do_reset("r026");
    cycle(4'b0100, 1'b0, "r026_grant");
    cycle(4'b0100, 1'b1, "r026_done");

    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, "r031_idle_done");

    for (int i = 0; i < 15; i++) cycle(4'b1111, (i % 3) == 2, "r027_rr");

    do_reset("r028");
    cycle(4'b0010, 1'b0, "r028_grant");
    cycle(4'b0010, 1'b0, "r028_hold");
    cycle(4'b0000, 1'b0, "r028_abort");
    cycle(4'b1111, 1'b0, "r028_ptr");

    cycle(4'b0001, 1'b0, "r029_grant");
    cycle(4'b0001, 1'b0, "r029_hold");
    do_reset("r029");
    cycle(4'b1000, 1'b0, "r029_after");
    cycle(4'b1000, 1'b0, "r029_hold2");

    do_reset("r030");
    for (int i = 0; i < 20; i++) cycle(4'b0011, 1'b0, "r030_timeout");

    r = 4'($urandom);
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      d = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
      else cycle(r, d, "rand");
    end

    @(posedge clock);
    #2;
    chk("drain", "queue_left", W'(sbq.size()), W'(0));
    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
